// File: rtl/xmpl_sram_pipe.sv
// Single-port SRAM with valid/ready request and response channels, byte-enabled writes,
// RD_LAT-cycle reads and a response FIFO that absorbs response-channel stalls.
module xmpl_sram_pipe #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DEPTH  = 4096,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned BE_W   = DATA_W / 8
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   input  logic [BE_W-1:0]   req_be_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_err_o,
   output logic [2:0]        outstanding_o
);

   localparam int unsigned FIFO_D = RD_LAT + 1;
   localparam int unsigned PTR_W  = $clog2(FIFO_D);
   localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   if (RD_LAT < 1 || RD_LAT > 4) begin : gen_bad_rd_lat
      $error("xmpl_sram_pipe: RD_LAT must be in 1..4");
   end
   if (DATA_W % 8 != 0 || BE_W != DATA_W / 8) begin : gen_bad_data_w
      $error("xmpl_sram_pipe: DATA_W must be a multiple of 8 and BE_W must equal DATA_W/8");
   end
   if (DEPTH < 1 || 64'(DEPTH) > (64'(1) << ADDR_W)) begin : gen_bad_depth
      $error("xmpl_sram_pipe: DEPTH must be in 1..2**ADDR_W");
   end

   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              rd_accept;
   logic              wr_accept;
   logic              in_range;
   logic              pop;
   logic [MEM_AW-1:0] mem_idx;
   logic [DATA_W-1:0] rd_data;

   logic              push_vld;
   logic              push_err;
   logic [DATA_W-1:0] push_data;

   logic [DATA_W-1:0] fifo_data_q [FIFO_D];
   logic [FIFO_D-1:0] fifo_err_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [2:0]        fifo_cnt_q;
   logic [2:0]        out_q;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Outstanding reads never exceed the FIFO depth, so every pipeline push has a free slot.
   assign req_ready_o = out_q < 3'(FIFO_D);
   assign accept      = req_valid_i && req_ready_o;
   assign rd_accept   = accept && !req_we_i;
   assign wr_accept   = accept && req_we_i;
   assign in_range    = {1'b0, req_addr_i} < (ADDR_W + 1)'(DEPTH);
   assign mem_idx     = req_addr_i[MEM_AW-1:0];
   assign rd_data     = in_range ? mem[mem_idx] : '0;
   assign pop         = rsp_valid_o && rsp_ready_i;

   always_ff @(posedge clk_i) begin
      if (wr_accept && in_range) begin
         for (int b = 0; b < int'(BE_W); b++) begin
            if (req_be_i[b]) mem[mem_idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
         end
      end
   end

   // The FIFO write is the last of the RD_LAT registers; extra latency goes in front of it.
   if (RD_LAT == 1) begin : gen_no_pipe
      assign push_vld  = rd_accept;
      assign push_err  = !in_range;
      assign push_data = rd_data;
   end else begin : gen_pipe
      logic [RD_LAT-2:0] vld_q;
      logic [RD_LAT-2:0] err_q;
      logic [DATA_W-1:0] data_q [RD_LAT-1];

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            vld_q <= '0;
            err_q <= '0;
            for (int i = 0; i < int'(RD_LAT) - 1; i++) data_q[i] <= '0;
         end else begin
            vld_q[0]  <= rd_accept;
            err_q[0]  <= !in_range;
            data_q[0] <= rd_data;
            for (int i = 1; i < int'(RD_LAT) - 1; i++) begin
               vld_q[i]  <= vld_q[i-1];
               err_q[i]  <= err_q[i-1];
               data_q[i] <= data_q[i-1];
            end
         end
      end

      assign push_vld  = vld_q[RD_LAT-2];
      assign push_err  = err_q[RD_LAT-2];
      assign push_data = data_q[RD_LAT-2];
   end

   always_ff @(posedge clk_i) begin
      if (push_vld) begin
         fifo_data_q[wr_ptr_q] <= push_data;
         fifo_err_q[wr_ptr_q]  <= push_err;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         out_q      <= '0;
      end else begin
         if (push_vld) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop)      rd_ptr_q <= ptr_inc(rd_ptr_q);
         fifo_cnt_q <= fifo_cnt_q + 3'(push_vld) - 3'(pop);
         out_q      <= out_q + 3'(rd_accept) - 3'(pop);
      end
   end

   assign rsp_valid_o   = fifo_cnt_q != 3'd0;
   assign rsp_data_o    = rsp_valid_o ? fifo_data_q[rd_ptr_q] : '0;
   assign rsp_err_o     = rsp_valid_o && fifo_err_q[rd_ptr_q];
   assign outstanding_o = out_q;

endmodule
